// File: rtl/control_pkg.sv
// Shared types and constants for the single-bus control sequencer.
// Optional illegal-opcode trap is enabled by defining ILLEGAL_OP_TRAP_EN.
package control_pkg;

    localparam int OPC_W_DEF    = 5;
    localparam int ALU_OP_W_DEF = 4;

    typedef logic [OPC_W_DEF-1:0]    op_t;
    typedef logic [ALU_OP_W_DEF-1:0] alu_t;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam op_t OP_LD   = 5'd0;
    localparam op_t OP_LDI  = 5'd1;
    localparam op_t OP_ST   = 5'd2;
    localparam op_t OP_ADD  = 5'd3;
    localparam op_t OP_SUB  = 5'd4;
    localparam op_t OP_AND  = 5'd5;
    localparam op_t OP_OR   = 5'd6;
    localparam op_t OP_ADDI = 5'd7;
    localparam op_t OP_BR   = 5'd8;
    localparam op_t OP_NOP  = 5'd9;
    localparam op_t OP_HALT = 5'd10;

    localparam alu_t ALU_ADD = 4'd0;
    localparam alu_t ALU_SUB = 4'd1;
    localparam alu_t ALU_AND = 4'd2;
    localparam alu_t ALU_OR  = 4'd3;

    typedef struct packed {
        logic pc_out, mdr_out, zlow_out, zhigh_out, c_out;
        logic r_out, ba_out, gra, grb, grc;
        logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, r_in, con_in;
        logic inc_pc, read, write, run;
        alu_t alu_op;
    } ctrl_t;

    function automatic logic op_defined(input op_t op);
        return op <= OP_HALT;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the datapath / select-encode logic.
// The illegal flag exists only when ILLEGAL_OP_TRAP_EN is defined.
interface control_sequencer_if
    import control_pkg::*;
#(
    parameter int OPC_W    = OPC_W_DEF,
    parameter int ALU_OP_W = ALU_OP_W_DEF
);
    logic [OPC_W-1:0]    ir_opcode;
    logic                con_ff;
    logic                mem_ready;
    logic                pc_out, mdr_out, zlow_out, zhigh_out, c_out;
    logic                r_out, ba_out, gra, grb, grc;
    logic                pc_in, ir_in, mar_in, mdr_in, y_in, z_in, r_in, con_in;
    logic                inc_pc, read, write, run;
    logic [ALU_OP_W-1:0] alu_op;
`ifdef ILLEGAL_OP_TRAP_EN
    logic                illegal;
`endif

    modport master (
        input  ir_opcode, con_ff, mem_ready,
`ifdef ILLEGAL_OP_TRAP_EN
        output illegal,
`endif
        output pc_out, mdr_out, zlow_out, zhigh_out, c_out,
        output r_out, ba_out, gra, grb, grc,
        output pc_in, ir_in, mar_in, mdr_in, y_in, z_in, r_in, con_in,
        output inc_pc, read, write, run, alu_op
    );

    modport slave (
        output ir_opcode, con_ff, mem_ready,
`ifdef ILLEGAL_OP_TRAP_EN
        input  illegal,
`endif
        input  pc_out, mdr_out, zlow_out, zhigh_out, c_out,
        input  r_out, ba_out, gra, grb, grc,
        input  pc_in, ir_in, mar_in, mdr_in, y_in, z_in, r_in, con_in,
        input  inc_pc, read, write, run, alu_op
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore FSM sequencing fetch/decode/execute of one instruction on the single-bus datapath.
// ILLEGAL_OP_TRAP_EN: undefined opcodes halt and raise illegal instead of acting as nop.
module control_sequencer
    import control_pkg::*;
#(
    parameter int OPC_W    = OPC_W_DEF,
    parameter int ALU_OP_W = ALU_OP_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    control_sequencer_if.master  bus
);
    state_t           r_state, w_next;
    logic             r_t1_wait;
    ctrl_t            w_c;
    logic [OPC_W-1:0] w_opc;
    op_t              w_op;
    logic             w_rr, w_ld, w_st, w_br, w_ldx;

    assign w_opc = bus.ir_opcode;
    assign w_op  = op_t'(w_opc);
    assign w_rr  = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_ld  = (w_op == OP_LD);
    assign w_st  = (w_op == OP_ST);
    assign w_br  = (w_op == OP_BR);
    // ldi, ld and st all start by forming base+offset with ba_out
    assign w_ldx = (w_op == OP_LDI) || w_ld || w_st;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_RESET;
            r_t1_wait <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_t1_wait <= (r_state == S_T1) && !bus.mem_ready;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_illegal <= 1'b0;
        else if (r_state == S_T2 && !op_defined(w_op))
            r_illegal <= 1'b1;
    end
    assign bus.illegal = r_illegal;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1:    w_next = bus.mem_ready ? S_T2 : S_T1;
            S_T2: begin
                if (w_rr || w_ldx || w_br || w_op == OP_ADDI) w_next = S_T3;
                else if (w_op == OP_HALT)                     w_next = S_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
                else if (!op_defined(w_op))                   w_next = S_HALT;
`endif
                else                                          w_next = S_T0;
            end
            S_T3:    w_next = S_T4;
            S_T4:    w_next = S_T5;
            S_T5:    w_next = (w_ld || w_st || w_br) ? S_T6 : S_T0;
            S_T6: begin
                if (w_ld)      w_next = bus.mem_ready ? S_T7 : S_T6;
                else if (w_st) w_next = S_T7;
                else           w_next = S_T0;
            end
            S_T7:    w_next = (w_st && !bus.mem_ready) ? S_T7 : S_T0;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RESET;
        endcase
    end

    always_comb begin
        w_c        = '0;
        w_c.run    = 1'b1;
        w_c.alu_op = ALU_ADD;
        case (r_state)
            S_T0: begin
                w_c.pc_out = 1'b1; w_c.mar_in = 1'b1; w_c.inc_pc = 1'b1; w_c.z_in = 1'b1;
            end
            S_T1: begin
                // PC update only on entry; wait cycles keep the read alive
                w_c.zlow_out = 1'b1; w_c.pc_in = !r_t1_wait; w_c.read = 1'b1; w_c.mdr_in = 1'b1;
            end
            S_T2: begin
                w_c.mdr_out = 1'b1; w_c.ir_in = 1'b1;
            end
            S_T3: begin
                if (w_rr || w_op == OP_ADDI) begin
                    w_c.grb = 1'b1; w_c.r_out = 1'b1; w_c.y_in = 1'b1;
                end else if (w_ldx) begin
                    w_c.grb = 1'b1; w_c.ba_out = 1'b1; w_c.y_in = 1'b1;
                end else if (w_br) begin
                    w_c.gra = 1'b1; w_c.r_out = 1'b1; w_c.con_in = 1'b1;
                end
            end
            S_T4: begin
                if (w_rr) begin
                    w_c.grc = 1'b1; w_c.r_out = 1'b1; w_c.z_in = 1'b1;
                    case (w_op)
                        OP_SUB:  w_c.alu_op = ALU_SUB;
                        OP_AND:  w_c.alu_op = ALU_AND;
                        OP_OR:   w_c.alu_op = ALU_OR;
                        default: w_c.alu_op = ALU_ADD;
                    endcase
                end else if (w_ldx || w_op == OP_ADDI) begin
                    w_c.c_out = 1'b1; w_c.z_in = 1'b1;
                end else if (w_br) begin
                    w_c.pc_out = 1'b1; w_c.y_in = 1'b1;
                end
            end
            S_T5: begin
                if (w_ld || w_st) begin
                    w_c.zlow_out = 1'b1; w_c.mar_in = 1'b1;
                end else if (w_br) begin
                    w_c.c_out = 1'b1; w_c.z_in = 1'b1;
                end else if (w_rr || w_op == OP_ADDI || w_op == OP_LDI) begin
                    w_c.zlow_out = 1'b1; w_c.gra = 1'b1; w_c.r_in = 1'b1;
                end
            end
            S_T6: begin
                if (w_ld) begin
                    w_c.read = 1'b1; w_c.mdr_in = 1'b1;
                end else if (w_st) begin
                    w_c.gra = 1'b1; w_c.r_out = 1'b1; w_c.mdr_in = 1'b1;
                end else if (w_br && bus.con_ff) begin
                    w_c.zlow_out = 1'b1; w_c.pc_in = 1'b1;
                end
            end
            S_T7: begin
                if (w_ld) begin
                    w_c.mdr_out = 1'b1; w_c.gra = 1'b1; w_c.r_in = 1'b1;
                end else if (w_st) begin
                    w_c.write = 1'b1;
                end
            end
            S_HALT:  w_c.run = 1'b0;
            default: ;
        endcase
    end

    assign bus.pc_out    = w_c.pc_out;
    assign bus.mdr_out   = w_c.mdr_out;
    assign bus.zlow_out  = w_c.zlow_out;
    assign bus.zhigh_out = w_c.zhigh_out;
    assign bus.c_out     = w_c.c_out;
    assign bus.r_out     = w_c.r_out;
    assign bus.ba_out    = w_c.ba_out;
    assign bus.gra       = w_c.gra;
    assign bus.grb       = w_c.grb;
    assign bus.grc       = w_c.grc;
    assign bus.pc_in     = w_c.pc_in;
    assign bus.ir_in     = w_c.ir_in;
    assign bus.mar_in    = w_c.mar_in;
    assign bus.mdr_in    = w_c.mdr_in;
    assign bus.y_in      = w_c.y_in;
    assign bus.z_in      = w_c.z_in;
    assign bus.r_in      = w_c.r_in;
    assign bus.con_in    = w_c.con_in;
    assign bus.inc_pc    = w_c.inc_pc;
    assign bus.read      = w_c.read;
    assign bus.write     = w_c.write;
    assign bus.run       = w_c.run;
    assign bus.alu_op    = ALU_OP_W'(w_c.alu_op);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-cycle control vectors compared against a microstep table model.
// Covers ILLEGAL_OP_TRAP_EN in both builds.
module tb_control_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cnt_read, cnt_pcin;

    always #5 clock = ~clock;

    control_sequencer_if bus ();
    control_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    localparam logic [21:0] PC_OUT = 22'(1) << 21, MDR_OUT = 22'(1) << 20, ZLOW = 22'(1) << 19,
                            ZHIGH = 22'(1) << 18, C_OUT = 22'(1) << 17, R_OUT = 22'(1) << 16,
                            BA_OUT = 22'(1) << 15, GRA = 22'(1) << 14, GRB = 22'(1) << 13,
                            GRC = 22'(1) << 12, PC_IN = 22'(1) << 11, IR_IN = 22'(1) << 10,
                            MAR_IN = 22'(1) << 9, MDR_IN = 22'(1) << 8, Y_IN = 22'(1) << 7,
                            Z_IN = 22'(1) << 6, R_IN = 22'(1) << 5, CON_IN = 22'(1) << 4,
                            INC_PC = 22'(1) << 3, READ = 22'(1) << 2, WRITE = 22'(1) << 1,
                            RUN = 22'(1);

    typedef struct {
        logic [21:0] m;
        logic [3:0]  alu;
        bit          rdy;
        bit          ill;
    } step_t;
    step_t exp_q[$];

    function automatic logic [21:0] obs();
        return {bus.pc_out, bus.mdr_out, bus.zlow_out, bus.zhigh_out, bus.c_out, bus.r_out,
                bus.ba_out, bus.gra, bus.grb, bus.grc, bus.pc_in, bus.ir_in, bus.mar_in,
                bus.mdr_in, bus.y_in, bus.z_in, bus.r_in, bus.con_in, bus.inc_pc, bus.read,
                bus.write, bus.run};
    endfunction

    function automatic bit ill_obs();
`ifdef ILLEGAL_OP_TRAP_EN
        return bus.illegal;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input logic [21:0] m, input logic [3:0] alu, input bit rdy, input bit halted, input bit ill);
        step_t s;
        s.m = halted ? m : (m | RUN);
        s.alu = alu; s.rdy = rdy; s.ill = ill;
        exp_q.push_back(s);
    endtask

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle control words for one instruction, from the microstep table
    task automatic build(input int opc, input bit con, input int wf, input int wm);
        push(PC_OUT | MAR_IN | INC_PC | Z_IN, 0, rnd(), 0, 0);
        for (int i = 0; i <= wf; i++)
            push(ZLOW | READ | MDR_IN | ((i == 0) ? PC_IN : 22'(0)), 0, i == wf, 0, 0);
        push(MDR_OUT | IR_IN, 0, rnd(), 0, 0);
        case (opc)
            3, 4, 5, 6: begin
                push(GRB | R_OUT | Y_IN, 0, rnd(), 0, 0);
                push(GRC | R_OUT | Z_IN, 4'(opc - 3), rnd(), 0, 0);
                push(ZLOW | GRA | R_IN, 0, rnd(), 0, 0);
            end
            1, 7: begin
                push(GRB | Y_IN | ((opc == 7) ? R_OUT : BA_OUT), 0, rnd(), 0, 0);
                push(C_OUT | Z_IN, 0, rnd(), 0, 0);
                push(ZLOW | GRA | R_IN, 0, rnd(), 0, 0);
            end
            0, 2: begin
                push(GRB | Y_IN | BA_OUT, 0, rnd(), 0, 0);
                push(C_OUT | Z_IN, 0, rnd(), 0, 0);
                push(ZLOW | MAR_IN, 0, rnd(), 0, 0);
                if (opc == 0) begin
                    for (int i = 0; i <= wm; i++) push(READ | MDR_IN, 0, i == wm, 0, 0);
                    push(MDR_OUT | GRA | R_IN, 0, rnd(), 0, 0);
                end else begin
                    push(GRA | R_OUT | MDR_IN, 0, rnd(), 0, 0);
                    for (int i = 0; i <= wm; i++) push(WRITE, 0, i == wm, 0, 0);
                end
            end
            8: begin
                push(GRA | R_OUT | CON_IN, 0, rnd(), 0, 0);
                push(PC_OUT | Y_IN, 0, rnd(), 0, 0);
                push(C_OUT | Z_IN, 0, rnd(), 0, 0);
                push(con ? (ZLOW | PC_IN) : 22'(0), 0, rnd(), 0, 0);
            end
            10: for (int i = 0; i < 20; i++) push(0, 0, rnd(), 1, 0);
            9: ;
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                for (int i = 0; i < 20; i++) push(0, 0, rnd(), 1, 1);
`endif
            end
        endcase
    endtask

    // Called #1 after a rising edge; consumes n expected steps (all if n<0)
    task automatic exec(input string name, input int n);
        int k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            step_t s = exp_q.pop_front();
            bus.mem_ready = s.rdy;
            #1;
            checks++;
            if (obs() !== s.m || bus.alu_op !== s.alu || ill_obs() !== s.ill) begin
                failures++;
                $display("FAIL %s step%0d: got ctrl=%h alu=%0d ill=%0b, want ctrl=%h alu=%0d ill=%0b",
                         name, k, obs(), bus.alu_op, ill_obs(), s.m, s.alu, s.ill);
            end
            if (bus.read === 1'b1) cnt_read++;
            if (bus.pc_in === 1'b1) cnt_pcin++;
            k++;
            @(posedge clock); #1;
        end
    endtask

    task automatic instr(input string name, input int opc, input bit con, input int wf, input int wm);
        bus.ir_opcode = 5'(opc);
        bus.con_ff = con;
        build(opc, con, wf, wm);
        exec(name, -1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== RUN || ill_obs() !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got ctrl=%h ill=%0b, want ctrl=%h ill=0", obs(), ill_obs(), RUN);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs() !== RUN) begin
            failures++;
            $display("FAIL reset_state: got ctrl=%h, want ctrl=%h", obs(), RUN);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_add();
        instr("add", 3, 0, 0, 0);
        instr("sub", 4, 0, 1, 0);
        instr("and", 5, 0, 0, 0);
        instr("or", 6, 0, 2, 0);
    endtask

    task automatic test_ld();
        cnt_read = 0; cnt_pcin = 0;
        instr("ld_wait", 0, 0, 3, 3);
        checks++;
        if (cnt_read != 8) begin
            failures++;
            $display("FAIL ld_read_cycles: got %0d, want 8", cnt_read);
        end
        checks++;
        if (cnt_pcin != 1) begin
            failures++;
            $display("FAIL ld_pcin_cycles: got %0d, want 1", cnt_pcin);
        end
    endtask

    task automatic test_st();
        cnt_read = 0;
        instr("st_wait", 2, 0, 0, 4);
        checks++;
        if (cnt_read != 1) begin
            failures++;
            $display("FAIL st_read_cycles: got %0d, want 1", cnt_read);
        end
        instr("st_fast", 2, 1, 1, 0);
    endtask

    task automatic test_br();
        instr("br_taken", 8, 1, 0, 0);
        instr("br_not", 8, 0, 0, 0);
        instr("nop", 9, 0, 0, 0);
        instr("addi", 7, 0, 0, 0);
        instr("ldi", 1, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int opc;
`ifdef ILLEGAL_OP_TRAP_EN
            opc = $urandom_range(0, 9);
`else
            do opc = $urandom_range(0, 31); while (opc == 10);
`endif
            instr("random", opc, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_undefined();
        instr("undef15", 15, 0, 1, 0);
`ifdef ILLEGAL_OP_TRAP_EN
        test_reset();
`endif
        instr("after_undef", 3, 0, 0, 0);
    endtask

    task automatic test_halt();
        instr("halt", 10, 0, 0, 0);
        test_reset();
        instr("after_halt", 6, 0, 0, 0);
    endtask

    task automatic test_reset_mid_ld();
        bus.ir_opcode = 5'd0;
        bus.con_ff = 1'b0;
        build(0, 0, 0, 3);
        exec("ld_pre_rst", 6);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.read !== 1'b1) begin
            failures++;
            $display("FAIL ld_t6_read: got %0b, want 1", bus.read);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== RUN) begin
            failures++;
            $display("FAIL rst_mid_ld: got ctrl=%h, want ctrl=%h", obs(), RUN);
        end
        exp_q.delete();
        test_reset();
        instr("after_rst", 0, 0, 0, 0);
    endtask

    initial begin
        bus.ir_opcode = '0;
        bus.con_ff = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_ld();
        test_st();
        test_br();
        test_undefined();
        test_random();
        test_reset_mid_ld();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
